// File: rtl/adc_reply_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_reply_receiver
//
// Receives the ADC's two-byte reply on a 250 kbaud 8N1 serial line (LSB first)
// and assembles a 16-bit sample {first byte, second byte}. The sample is handed
// to the consumer over a valid/ready handshake. One-cycle pulses report a bad
// stop bit, a second byte that never started, and a sample overwritten before
// it was taken.
//
// Optional build macro:
//   ADC_RX_MAJORITY_EN  each bit decision is a 2-of-3 vote over three
//                       consecutive synchronised samples. The decision lands
//                       one clock later than the single-sample build.
//
// Ports:
//   clk12MHz      in   system clock
//   reset_n       in   asynchronous active-low reset
//   rx            in   serial line, idle high, asynchronous to clk12MHz
//   sample        out  assembled reading {byte1, byte2}; stable while valid
//   sample_valid  out  sample available; held until accepted
//   sample_ready  in   consumer ready
//   busy          out  receiver mid-frame or holding byte 1
//   frame_err     out  pulse: stop bit sampled low
//   timeout_err   out  pulse: byte 2 did not start in time
//   overrun       out  pulse: sample replaced while still unaccepted
//
// Handshake: a sample transfers on every clock edge where sample_valid and
// sample_ready are both high. sample_valid never drops without a transfer,
// and sample does not change while sample_valid is high unless a newer sample
// replaces it (signalled by overrun).
// -----------------------------------------------------------------------------
module adc_reply_receiver #(
   parameter int CLKS_PER_BIT = 48,
   parameter int TIMEOUT_CLKS = 960
) (
   input  logic        clk12MHz,
   input  logic        reset_n,
   input  logic        rx,
   output logic [15:0] sample,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        busy,
   output logic        frame_err,
   output logic        timeout_err,
   output logic        overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef ADC_RX_MAJORITY_EN
   // The vote needs the sample one cycle past mid, so the start check (and
   // with it the whole bit grid) lands one cycle later.
   localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2);
`else
   localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2 - 1);
`endif
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q;
   logic          rs_q;
   logic          rs_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          byte_idx_q, byte_idx_d;
   logic [7:0]    hi_q, hi_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [15:0]   sample_q, sample_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;
   logic          timeout_err_q, timeout_err_d;
   logic          overrun_q, overrun_d;

   logic          bit_val;
   logic          byte_good;
   logic          byte_bad;

`ifdef ADC_RX_MAJORITY_EN
   // hist_q[0] is rs one cycle back, hist_q[1] two cycles back.
   logic [1:0] hist_q;

   always_ff @(posedge clk12MHz or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rs_q};
      end
   end

   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rs_q) | (hist_q[0] & rs_q);
`else
   assign bit_val = rs_q;
`endif

   // Synchroniser and edge-detect history; all reset to the idle-high level.
   always_ff @(posedge clk12MHz or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= 1'b1;
         rs_q      <= 1'b1;
         rs_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx;
         rs_q      <= sync1_q;
         rs_prev_q <= rs_q;
      end
   end

   always_ff @(posedge clk12MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         byte_idx_q    <= 1'b0;
         hi_q          <= '0;
         tmo_q         <= '0;
         sample_q      <= '0;
         valid_q       <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         byte_idx_q    <= byte_idx_d;
         hi_q          <= hi_d;
         tmo_q         <= tmo_d;
         sample_q      <= sample_d;
         valid_q       <= valid_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      byte_idx_d    = byte_idx_q;
      hi_d          = hi_q;
      tmo_d         = tmo_q;
      sample_d      = sample_q;
      valid_d       = valid_q;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;
      overrun_d     = 1'b0;
      byte_good     = 1'b0;
      byte_bad      = 1'b0;

      case (state_q)
         IDLE: begin
            if (rs_prev_q && !rs_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == START_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               // A line back high at mid start bit was only a glitch.
               state_d   = bit_val ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {bit_val, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               // Leave mid stop bit so a following start edge is caught at once.
               cnt_d     = '0;
               state_d   = IDLE;
               byte_good = bit_val;
               byte_bad  = !bit_val;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (valid_q && sample_ready) begin
         valid_d = 1'b0;
      end

      // Idle time between bytes only counts while the line is idle.
      if ((state_q == IDLE) && byte_idx_q) begin
         if (tmo_q == TMO_LAST) begin
            timeout_err_d = 1'b1;
            byte_idx_d    = 1'b0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      if (byte_bad) begin
         frame_err_d = 1'b1;
         byte_idx_d  = 1'b0;
      end

      if (byte_good) begin
         if (!byte_idx_q) begin
            hi_d       = shift_q;
            byte_idx_d = 1'b1;
            tmo_d      = '0;
         end else begin
            sample_d   = {hi_q, shift_q};
            byte_idx_d = 1'b0;
            valid_d    = 1'b1;
            overrun_d  = valid_q && !sample_ready;
         end
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign busy         = (state_q != IDLE) || byte_idx_q;
   assign frame_err    = frame_err_q;
   assign timeout_err  = timeout_err_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_reply_receiver.sv
`timescale 1ns/1ps
module tb_adc_reply_receiver;

   localparam int CPB = 48;
   localparam int TMO = 960;
`ifdef ADC_RX_MAJORITY_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   // ---------------- clock / reset ----------------
   logic        clk12MHz = 1'b0;
   logic        reset_n;
   logic        rx;
   logic        sample_ready;
   logic [15:0] sample;
   logic        sample_valid;
   logic        busy;
   logic        frame_err;
   logic        timeout_err;
   logic        overrun;

   always #42 clk12MHz = ~clk12MHz;

   int cyc = 0;
   always @(posedge clk12MHz) cyc <= cyc + 1;

   adc_reply_receiver dut (
      .clk12MHz     (clk12MHz),
      .reset_n      (reset_n),
      .rx           (rx),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .busy         (busy),
      .frame_err    (frame_err),
      .timeout_err  (timeout_err),
      .overrun      (overrun)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- monitor ----------------
   logic [15:0] act_q[$];
   int          ferr_cnt = 0;
   int          terr_cnt = 0;
   int          ovr_cnt  = 0;
   int          terr_cyc = -1;
   int          rise_cyc = -1;
   logic        valid_prev = 1'b0;

   always @(negedge clk12MHz) begin
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (timeout_err === 1'b1) begin
         terr_cnt++;
         terr_cyc = cyc;
      end
      if (sample_valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
      if (sample_valid === 1'b1 && sample_ready === 1'b1) act_q.push_back(sample);
      valid_prev = sample_valid;
   end

   // ---------------- reference model ----------------
   logic [15:0] exp_q[$];
   int          exp_ferr = 0;
   int          exp_terr = 0;
   int          exp_ovr  = 0;
   bit          m_pend   = 0;
   logic [7:0]  m_hi     = 8'h00;
   bit          m_ready  = 1;
   bit          m_held_v = 0;
   logic [15:0] m_held   = 16'h0000;

   task automatic model_byte(input bit good, input logic [7:0] b);
      logic [15:0] v;
      if (!good) begin
         exp_ferr++;
         m_pend = 0;
      end else if (!m_pend) begin
         m_pend = 1;
         m_hi   = b;
      end else begin
         m_pend = 0;
         v = {m_hi, b};
         if (m_ready) begin
            exp_q.push_back(v);
         end else begin
            if (m_held_v) exp_ovr++;
            m_held   = v;
            m_held_v = 1;
         end
      end
   endtask

   task automatic model_idle(input int n);
      if (m_pend && n > TMO) begin
         exp_terr++;
         m_pend = 0;
      end
   endtask

   // ---------------- drivers ----------------
   int start_cyc = 0;

   // glitch_bit selects a data bit whose mid-bit clock is inverted for one cycle.
   task automatic send_byte(input logic [7:0] b, input bit stop_bit, input int glitch_bit);
      @(negedge clk12MHz);
      rx = 1'b0;
      start_cyc = cyc;
      repeat (CPB) @(negedge clk12MHz);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == glitch_bit) begin
            repeat (CPB / 2) @(negedge clk12MHz);
            rx = ~b[i];
            @(negedge clk12MHz);
            rx = b[i];
            repeat (CPB / 2 - 1) @(negedge clk12MHz);
         end else begin
            repeat (CPB) @(negedge clk12MHz);
         end
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk12MHz);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk12MHz);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      sample_ready = 1'b1;
      repeat (3) @(negedge clk12MHz);
      n_cmp++; if (sample !== 16'h0000) begin n_err++; $display("FAIL reset_sample: got %h expected 0000", sample); end
      n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if ({frame_err, timeout_err, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {frame_err, timeout_err, overrun}); end
      reset_n = 1'b1;
      idle(5);
   endtask

   task automatic test_basic();
      int s2;
      send_byte(8'h03, 1, -1); model_byte(1, 8'h03);
      idle(2 * CPB);
      send_byte(8'h9C, 1, -1); model_byte(1, 8'h9C);
      s2 = start_cyc;
      idle(100);
      n_cmp++; if (rise_cyc - s2 !== 459 + LAT) begin n_err++; $display("FAIL basic_valid_latency: got %0d expected %0d", rise_cyc - s2, 459 + LAT); end
      n_cmp++; if (exp_q.size() !== 1 || exp_q[0] !== 16'h039C) begin n_err++; $display("FAIL basic_model: got %0d entries expected 1 of 039c", exp_q.size()); end
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_sample: got %h expected %h", act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_frame();
      send_byte(8'hA5, 0, -1); model_byte(0, 8'hA5);
      idle(2 * CPB);
      n_cmp++; if (ferr_cnt !== exp_ferr) begin n_err++; $display("FAIL frame_err_count: got %0d expected %0d", ferr_cnt, exp_ferr); end
      n_cmp++; if (act_q.size() != 0) begin n_err++; $display("FAIL frame_no_valid: got %0d accepts expected 0", act_q.size()); end
      send_byte(8'h12, 1, -1); model_byte(1, 8'h12);
      idle(2 * CPB);
      send_byte(8'h34, 1, -1); model_byte(1, 8'h34);
      idle(100);
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL frame_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL frame_sample: got %h expected %h", act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_timeout();
      int s1;
      terr_cyc = -1;
      send_byte(8'h55, 1, -1); model_byte(1, 8'h55);
      s1 = start_cyc;
      idle(1000); model_idle(1000);
      n_cmp++; if (terr_cnt !== exp_terr) begin n_err++; $display("FAIL timeout_count: got %0d expected %0d", terr_cnt, exp_terr); end
      n_cmp++; if (terr_cyc - s1 !== 459 + LAT + TMO) begin n_err++; $display("FAIL timeout_latency: got %0d expected %0d", terr_cyc - s1, 459 + LAT + TMO); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b expected 0", busy); end
      send_byte(8'h01, 1, -1); model_byte(1, 8'h01);
      idle(2 * CPB);
      send_byte(8'h02, 1, -1); model_byte(1, 8'h02);
      idle(100);
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL timeout_acc_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL timeout_sample: got %h expected %h", act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_overrun();
      logic [7:0] bytes [4];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      @(posedge clk12MHz); #1 sample_ready = 1'b0;
      m_ready = 0;
      for (int i = 0; i < 4; i++) begin
         send_byte(bytes[i], 1, -1); model_byte(1, bytes[i]);
         idle(2 * CPB);
      end
      n_cmp++; if (ovr_cnt !== exp_ovr) begin n_err++; $display("FAIL overrun_count: got %0d expected %0d", ovr_cnt, exp_ovr); end
      n_cmp++; if (sample !== m_held) begin n_err++; $display("FAIL overrun_sample: got %h expected %h", sample, m_held); end
      n_cmp++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL overrun_valid_held: got %b expected 1", sample_valid); end
      @(posedge clk12MHz); #1 sample_ready = 1'b1;
      m_ready = 1;
      if (m_held_v) begin exp_q.push_back(m_held); m_held_v = 0; end
      @(negedge clk12MHz);
      @(negedge clk12MHz);
      n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL overrun_valid_drop: got %b expected 0", sample_valid); end
      n_cmp++; if (sample !== 16'h3344) begin n_err++; $display("FAIL overrun_sample_hold: got %h expected 3344", sample); end
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL overrun_acc_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL overrun_accept: got %h expected %h", act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_glitch();
      logic [7:0] first;
      @(negedge clk12MHz);
      rx = 1'b0;
      repeat (10) @(negedge clk12MHz);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
      rx = 1'b1;
      repeat (40) @(negedge clk12MHz);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_back_idle: got %b expected 0", busy); end
      n_cmp++; if (ferr_cnt !== exp_ferr || terr_cnt !== exp_terr || ovr_cnt !== exp_ovr) begin
         n_err++; $display("FAIL glitch_no_flags: got %0d/%0d/%0d expected %0d/%0d/%0d", ferr_cnt, terr_cnt, ovr_cnt, exp_ferr, exp_terr, exp_ovr);
      end
      // A one-clock flip at mid bit 3: outvoted with majority, captured without.
`ifdef ADC_RX_MAJORITY_EN
      first = 8'h5A;
`else
      first = 8'h5A ^ 8'h08;
`endif
      send_byte(8'h5A, 1, 3); model_byte(1, first);
      idle(2 * CPB);
      send_byte(8'hC3, 1, -1); model_byte(1, 8'hC3);
      idle(100);
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL glitch_acc_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL glitch_sample: got %h expected %h", act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'h77, 1, -1); model_byte(1, 8'h77);
      idle(2 * CPB);
      @(negedge clk12MHz);
      rx = 1'b0;
      repeat (150) @(negedge clk12MHz);
      reset_n = 1'b0;
      #1;
      n_cmp++; if (sample !== 16'h0000) begin n_err++; $display("FAIL midreset_sample: got %h expected 0000", sample); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      n_cmp++; if ({sample_valid, frame_err, timeout_err, overrun} !== 4'b0000) begin
         n_err++; $display("FAIL midreset_outputs: got %b expected 0000", {sample_valid, frame_err, timeout_err, overrun});
      end
      rx = 1'b1;
      m_pend = 0; m_held_v = 0;
      repeat (5) @(negedge clk12MHz);
      reset_n = 1'b1;
      idle(10);
      send_byte(8'hBE, 1, -1); model_byte(1, 8'hBE);
      idle(2 * CPB);
      send_byte(8'hEF, 1, -1); model_byte(1, 8'hEF);
      idle(100);
      n_cmp++; if (ferr_cnt !== exp_ferr) begin n_err++; $display("FAIL midreset_no_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL midreset_acc_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midreset_sample_after: got %h expected %h", act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         good;
      int         gap;
      for (int k = 0; k < 14; k++) begin
         b    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 5) != 0);
         send_byte(b, good, -1); model_byte(good, b);
         if ($urandom_range(0, 7) == 0) gap = 1000;
         else if (good) gap = $urandom_range(0, 150);
         else gap = $urandom_range(CPB, 150);
         idle(gap); model_idle(gap);
      end
      idle(100);
      n_cmp++; if (ferr_cnt !== exp_ferr) begin n_err++; $display("FAIL random_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
      n_cmp++; if (terr_cnt !== exp_terr) begin n_err++; $display("FAIL random_terr: got %0d expected %0d", terr_cnt, exp_terr); end
      n_cmp++; if (ovr_cnt !== exp_ovr) begin n_err++; $display("FAIL random_ovr: got %0d expected %0d", ovr_cnt, exp_ovr); end
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_acc_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_sample: got %h expected %h", act_q[i], exp_q[i]); end
      end
      act_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame();
      test_timeout();
      test_overrun();
      test_glitch();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
